gf180_ram_word_bridge: RTL and testbench



---
 rtl/gf180_ram_pkg.sv | 21 ++
 rtl/gf180_ram_word_bridge.sv | 182 ++++++++++++++++++
 tb/tb_gf180_ram_word_bridge.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf180_ram_pkg.sv
// rtl/gf180_ram_pkg.sv - shared constants and FSM states for the GF180 RAM word bridge
package gf180_ram_pkg;

    localparam int RAM_AW = 9;
    localparam int LANES  = 4;

    // Macro control pins are all active low
    localparam logic       CEN_ON   = 1'b0;
    localparam logic       GWEN_WR  = 1'b0;
    localparam logic [7:0] WEN_ALL  = 8'h00;
    localparam logic [7:0] WEN_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RFLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gf180_ram_word_bridge.sv
// rtl/gf180_ram_word_bridge.sv - serialises 32-bit PicoRV32 accesses into four byte cycles on a 512x8 macro
module gf180_ram_word_bridge
    import gf180_ram_pkg::*;
#(
    parameter int RAM_DEPTH = 1 << RAM_AW,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    output logic          ram_cen,
    output logic          ram_gwen,
    output logic [7:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    state_e        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-3:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;

    logic          ram_cen_q, ram_cen_d;
    logic          ram_gwen_q, ram_gwen_d;
    logic [7:0]    ram_wen_q, ram_wen_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          mem_ready_q, mem_ready_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    // Per-cycle macro command request, resolved into pin values once below
    logic          issue, issue_rd;
    logic [1:0]    issue_lane;
    logic [AW-3:0] issue_waddr;
    logic [31:0]   issue_wdata;
    logic [3:0]    issue_wstrb;

    // High address bits alias and the byte offset is ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:AW], mem_addr[1:0]};

    // Next-state, lane sequencing, read-byte capture and macro command decode
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ram_cen_d   = ~CEN_ON;
        ram_gwen_d  = ~GWEN_WR;
        ram_wen_d   = WEN_NONE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        issue       = 1'b0;
        issue_rd    = 1'b0;
        issue_lane  = lane_q;
        issue_waddr = waddr_q;
        issue_wdata = wdata_q;
        issue_wstrb = wstrb_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    waddr_d     = mem_addr[AW-1:2];
                    wdata_d     = mem_wdata;
                    wstrb_d     = mem_wstrb;
                    lane_d      = 2'd0;
                    issue       = 1'b1;
                    issue_rd    = (mem_wstrb == 4'd0);
                    issue_lane  = 2'd0;
                    issue_waddr = mem_addr[AW-1:2];
                    issue_wdata = mem_wdata;
                    issue_wstrb = mem_wstrb;
                    state_d     = issue_rd ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (lane_q == LAST_LANE) begin
                    state_d     = ST_DONE;
                    mem_ready_d = 1'b1;
                end else begin
                    lane_d     = lane_q + 2'd1;
                    issue      = 1'b1;
                    issue_lane = lane_d;
                end
            end
            ST_READ: begin
                // Macro data lags the issued lane by one cycle
                if (lane_q != 2'd0) begin
                    mem_rdata_d[{lane_q - 2'd1, 3'b000} +: 8] = ram_rdata;
                end
                if (lane_q == LAST_LANE) begin
                    state_d = ST_RFLUSH;
                end else begin
                    lane_d     = lane_q + 2'd1;
                    issue      = 1'b1;
                    issue_rd   = 1'b1;
                    issue_lane = lane_d;
                end
            end
            ST_RFLUSH: begin
                mem_rdata_d[{LAST_LANE, 3'b000} +: 8] = ram_rdata;
                state_d     = ST_DONE;
                mem_ready_d = 1'b1;
            end
            ST_DONE: begin
                // mem_valid deliberately ignored here so a held request is not replayed
                state_d = ST_IDLE;
                lane_d  = 2'd0;
            end
            default: begin
                state_d = ST_IDLE;
                lane_d  = 2'd0;
            end
        endcase

        if (issue) begin
            ram_addr_d = {issue_waddr, issue_lane};
            if (issue_rd) begin
                ram_cen_d = CEN_ON;
            end else begin
                ram_wdata_d = issue_wdata[{issue_lane, 3'b000} +: 8];
                if (issue_wstrb[issue_lane]) begin
                    ram_cen_d  = CEN_ON;
                    ram_gwen_d = GWEN_WR;
                    ram_wen_d  = WEN_ALL;
                end
            end
        end
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            lane_q      <= 2'd0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ram_cen_q   <= ~CEN_ON;
            ram_gwen_q  <= ~GWEN_WR;
            ram_wen_q   <= WEN_NONE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ram_cen_q   <= ram_cen_d;
            ram_gwen_q  <= ram_gwen_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_cen   = ram_cen_q;
    assign ram_gwen  = ram_gwen_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_gf180_ram_word_bridge.sv
// tb/tb_gf180_ram_word_bridge.sv - scoreboard bench for gf180_ram_word_bridge with macro model
module tb_gf180_ram_word_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        ram_cen;
    logic        ram_gwen;
    logic [7:0]  ram_wen;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    always #5 clk = ~clk;

    gf180_ram_word_bridge dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } rsp_t;

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] data;
    } op_t;

    rsp_t rsp_q[$];
    op_t  op_q[$];
    rsp_t mr;
    op_t  mo;

    logic [7:0]  ref_mem [512];
    logic [7:0]  mac_mem [512];
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Macro: command latched mid-cycle, executed on the next rising edge
    logic       c_cen = 1'b1;
    logic       c_gwen = 1'b1;
    logic [7:0] c_wen = 8'hFF;
    logic [8:0] c_addr = '0;
    logic [7:0] c_wdata = '0;

    always @(negedge clk) begin
        c_cen   = ram_cen;
        c_gwen  = ram_gwen;
        c_wen   = ram_wen;
        c_addr  = ram_addr;
        c_wdata = ram_wdata;
        if (resetn && !ram_cen) begin
            if (op_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL macro_unexpected: got command at addr %h gwen %b, expected none", ram_addr, ram_gwen);
            end else begin
                mo = op_q.pop_front();
                chk("macro_is_write", {31'd0, ~ram_gwen}, {31'd0, mo.wr});
                chk("macro_addr", {23'd0, ram_addr}, {23'd0, mo.addr});
                if (mo.wr) begin
                    chk("macro_wen", {24'd0, ram_wen}, 32'h0);
                    chk("macro_wdata", {24'd0, ram_wdata}, {24'd0, mo.data});
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!c_cen) begin
            if (!c_gwen) mac_mem[c_addr] = (mac_mem[c_addr] & c_wen) | (c_wdata & ~c_wen);
            else         ram_rdata <= mac_mem[c_addr];
        end
    end

    // Response monitor: every ready pulse must match the oldest outstanding access
    always @(negedge clk) begin
        if (resetn && mem_ready) begin
            if (rsp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ready_unexpected: got mem_ready=1 with no access outstanding (cycle %0d)", cyc);
            end else begin
                mr = rsp_q.pop_front();
                chk("latency", cyc - mr.issue - 1, mr.lat);
                chk(mr.is_read ? "read_rdata" : "write_keeps_rdata", mem_rdata, mr.rdata);
            end
        end
    end

    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit early_drop);
        rsp_t       r;
        op_t        o;
        logic [8:0] base;
        bit         seen;
        base = {addr[8:2], 2'b00};
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            o.addr = base + 9'(k);
            o.data = wdata[8*k +: 8];
            if (strb == 4'd0) begin
                o.wr = 1'b0;
                op_q.push_back(o);
            end else if (strb[k]) begin
                o.wr = 1'b1;
                op_q.push_back(o);
                ref_mem[o.addr] = o.data;
            end
        end
        r.is_read = (strb == 4'd0);
        if (r.is_read) begin
            r.rdata = {ref_mem[base + 9'd3], ref_mem[base + 9'd2], ref_mem[base + 9'd1], ref_mem[base]};
            last_rd = r.rdata;
        end else begin
            r.rdata = last_rd;
        end
        r.lat   = r.is_read ? 5 : 4;
        r.issue = cyc;
        rsp_q.push_back(r);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        if (early_drop) begin
            @(posedge clk);
            #1 mem_valid = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got no mem_ready within 20 cycles, expected one for addr %h", addr);
        end
        // valid is still high across the DONE edge; it must not start a second access
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cen"},   {31'd0, ram_cen}, 32'd1);
        chk({tag, "_gwen"},  {31'd0, ram_gwen}, 32'd1);
        chk({tag, "_wen"},   {24'd0, ram_wen}, 32'hFF);
        chk({tag, "_addr"},  {23'd0, ram_addr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, ram_wdata}, 32'd0);
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_rdata"}, mem_rdata, 32'd0);
    endtask

    // Full write cut by reset just after the edge that writes lane 1
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata);
        op_t        o;
        logic [8:0] base;
        base = {addr[8:2], 2'b00};
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            o.wr   = 1'b1;
            o.addr = base + 9'(k);
            o.data = wdata[8*k +: 8];
            op_q.push_back(o);
            ref_mem[o.addr] = o.data;
        end
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        #1;
        check_reset_outputs("abort");
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_ready", {31'd0, mem_ready}, 32'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  v;
        logic [3:0]  s;
        for (int i = 0; i < 512; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            mac_mem[i] = v;
        end

        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_cen", {31'd0, ram_cen}, 32'd1);
        end

        access(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0);
        access(32'h0000_0010, 32'h0, 4'h0, 0);
        access(32'h0000_0010, 32'h11223344, 4'b0101, 0);
        access(32'h0000_0010, 32'h0, 4'h0, 0);
        chk("partial_model", last_rd, 32'hDE22BE44);
        access(32'h0000_0210, 32'h0, 4'h0, 0);
        access(32'h0000_01FC, 32'h0, 4'h0, 0);
        access(32'h0000_0013, 32'h0, 4'h0, 0);
        access(32'hFFFF_FFFE, 32'hA5C3_7E01, 4'b1000, 0);
        access(32'h0000_01FC, 32'h0, 4'h0, 0);
        access(32'h0000_0080, 32'h0BAD_CAFE, 4'b0011, 1);
        access(32'h0000_0080, 32'h0, 4'h0, 1);

        for (int i = 0; i < 40; i++) begin
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            access($urandom, $urandom, s, $urandom_range(0, 7) == 0);
        end

        abort_write(32'h0000_0040, 32'hCAFE_F00D);
        access(32'h0000_0040, 32'h0, 4'h0, 0);

        repeat (4) @(negedge clk);
        chk("rsp_drained", rsp_q.size(), 32'd0);
        chk("ops_drained", op_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
